seq_pass_fail_counter: RTL and testbench

SEQ_PASS_FAIL_COUNTER -- requirements
Module: seq_pass_fail_counter

---
 rtl/seq_pass_fail_counter.sv | 102 ++++++++++
 tb/tb_seq_pass_fail_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pass_fail_counter.sv
// Per-channel checker for the property a |=> b ##1 c, with saturating pass/fail counters.
// Pass counting is held off for WARMUP edges after reset; failures always count.
module seq_pass_fail_counter #(
  parameter int NCH           = 4,
  parameter int CW            = 8,
  parameter int WARMUP        = 20,
  parameter int COUNT_VACUOUS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    a,
  input  logic [NCH-1:0]    b,
  input  logic [NCH-1:0]    c,
  input  logic              clr,
  output logic [NCH*CW-1:0] pass_count,
  output logic [NCH*CW-1:0] fail_count,
  output logic [NCH-1:0]    fail_pulse,
  output logic              pass_en,
  output logic [NCH-1:0]    sat
);

  localparam logic [CW:0] CMAX    = {1'b0, {CW{1'b1}}};
  localparam logic [16:0] WARM_TC = 17'(WARMUP);
  localparam logic        VAC     = (COUNT_VACUOUS != 0);

  logic [NCH-1:0]    s1;
  logic [NCH-1:0]    s2;
  logic [16:0]       warm_cnt;
  logic              pass_en_q;

  logic [NCH*CW-1:0] pass_nxt;
  logic [NCH*CW-1:0] fail_nxt;
  logic [NCH-1:0]    pulse_nxt;
  logic [NCH-1:0]    sat_nxt;
  logic [1:0]        pinc [NCH];
  logic [1:0]        finc [NCH];
  logic [CW:0]       psum [NCH];
  logic [CW:0]       fsum [NCH];

  // With no warm-up, passes are enabled as soon as reset is released.
  assign pass_en = (WARMUP == 0) ? ~rst : pass_en_q;

  always_comb begin
    pass_nxt  = pass_count;
    fail_nxt  = fail_count;
    pulse_nxt = '0;
    sat_nxt   = sat;
    for (int i = 0; i < NCH; i++) begin
      pinc[i] = '0;
      finc[i] = {1'b0, s1[i] & ~b[i]} + {1'b0, s2[i] & ~c[i]};
      if (pass_en)
        pinc[i] = {1'b0, s2[i] & c[i]} + {1'b0, VAC & ~a[i]};
      psum[i] = {1'b0, pass_count[i*CW +: CW]} + {{(CW-1){1'b0}}, pinc[i]};
      fsum[i] = {1'b0, fail_count[i*CW +: CW]} + {{(CW-1){1'b0}}, finc[i]};
      pulse_nxt[i] = |finc[i];
      if (psum[i] > CMAX) begin
        pass_nxt[i*CW +: CW] = '1;
        sat_nxt[i]           = 1'b1;
      end else begin
        pass_nxt[i*CW +: CW] = psum[i][CW-1:0];
      end
      if (fsum[i] > CMAX) begin
        fail_nxt[i*CW +: CW] = '1;
        sat_nxt[i]           = 1'b1;
      end else begin
        fail_nxt[i*CW +: CW] = fsum[i][CW-1:0];
      end
    end
    // Clear wins over anything resolving on the same edge.
    if (clr) begin
      pass_nxt  = '0;
      fail_nxt  = '0;
      pulse_nxt = '0;
      sat_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      warm_cnt   <= '0;
      pass_en_q  <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      fail_pulse <= '0;
      sat        <= '0;
    end else begin
      s1         <= a;
      s2         <= s1 & b;
      if (!pass_en_q) begin
        warm_cnt  <= warm_cnt + 17'd1;
        pass_en_q <= (warm_cnt + 17'd1) >= WARM_TC;
      end
      pass_count <= pass_nxt;
      fail_count <= fail_nxt;
      fail_pulse <= pulse_nxt;
      sat        <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_seq_pass_fail_counter.sv
// Directed bench for seq_pass_fail_counter: an edge-indexed history model checked every
// cycle against two instances (plain and vacuous-counting), plus literal spot checks.
module tb_seq_pass_fail_counter;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int WU  = 20;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [NCH-1:0] a = '0, b = '0, c = '0;

  logic [NCH*CW-1:0] pc0, fc0, pc1, fc1;
  logic [NCH-1:0]    fp0, sat0, fp1, sat1;
  logic              pe0, pe1;

  int n_assert = 0;
  int n_fail   = 0;

  seq_pass_fail_counter #(.NCH(NCH), .CW(CW), .WARMUP(WU), .COUNT_VACUOUS(0)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .clr(clr),
    .pass_count(pc0), .fail_count(fc0), .fail_pulse(fp0), .pass_en(pe0), .sat(sat0));

  seq_pass_fail_counter #(.NCH(NCH), .CW(CW), .WARMUP(WU), .COUNT_VACUOUS(1)) u_vac (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .clr(clr),
    .pass_count(pc1), .fail_count(fc1), .fail_pulse(fp1), .pass_en(pe1), .sat(sat1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: inputs recorded by edge number since reset release; each edge resolves the
  // attempt started one edge ago (needs b now) and the one started two edges ago (needs c now).
  int e = 0;
  logic [NCH-1:0] ah [int];
  logic [NCH-1:0] bh [int];
  int  mp [2][NCH];
  int  mf [2][NCH];
  bit  ms [2][NCH];
  bit  mpulse [NCH];
  bit  mpen = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e = 0;
      ah.delete();
      bh.delete();
      mpen = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NCH; i++) begin
          mp[k][i] = 0; mf[k][i] = 0; ms[k][i] = 1'b0;
        end
      for (int i = 0; i < NCH; i++) mpulse[i] = 1'b0;
    end else begin
      e++;
      ah[e] = a;
      bh[e] = b;
      for (int i = 0; i < NCH; i++) begin
        int nf, np;
        nf = 0; np = 0;
        if (e >= 2 && ah[e-1][i] && !b[i]) nf++;
        if (e >= 3 && ah[e-2][i] && bh[e-1][i]) begin
          if (c[i]) np++; else nf++;
        end
        for (int k = 0; k < 2; k++) begin
          int add;
          add = 0;
          if (e - 1 >= WU) add = np + ((k == 1 && !a[i]) ? 1 : 0);
          if (clr) begin
            mp[k][i] = 0; mf[k][i] = 0; ms[k][i] = 1'b0;
          end else begin
            mp[k][i] += add;
            mf[k][i] += nf;
            if (mp[k][i] > MAXC) begin mp[k][i] = MAXC; ms[k][i] = 1'b1; end
            if (mf[k][i] > MAXC) begin mf[k][i] = MAXC; ms[k][i] = 1'b1; end
          end
        end
        mpulse[i] = !clr && nf > 0;
      end
      mpen = (e >= WU);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pass_en", pe0, mpen);
      chk("pass_en_vac", pe1, mpen);
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("pass_count[%0d]", i), pc0[i*CW +: CW], mp[0][i]);
        chk($sformatf("fail_count[%0d]", i), fc0[i*CW +: CW], mf[0][i]);
        chk($sformatf("fail_pulse[%0d]", i), fp0[i], mpulse[i]);
        chk($sformatf("sat[%0d]", i), sat0[i], ms[0][i]);
        chk($sformatf("vac_pass_count[%0d]", i), pc1[i*CW +: CW], mp[1][i]);
        chk($sformatf("vac_fail_count[%0d]", i), fc1[i*CW +: CW], mf[1][i]);
        chk($sformatf("vac_fail_pulse[%0d]", i), fp1[i], mpulse[i]);
        chk($sformatf("vac_sat[%0d]", i), sat1[i], ms[1][i]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"}, pc0, 0);
    chk({tag, "_fc"}, fc0, 0);
    chk({tag, "_fp"}, fp0, 0);
    chk({tag, "_pe"}, pe0, 0);
    chk({tag, "_sat"}, sat0, 0);
    chk({tag, "_vac_pc"}, pc1, 0);
    chk({tag, "_vac_pe"}, pe1, 0);
  endtask

  initial begin
    a[0] = 1'b1; b[0] = 1'b1; c[0] = 1'b1;
    tick(2);
    chk_all_zero("reset");
    rst = 1'b0;

    // Failure during warm-up on ch1: a at edge 3, b low at edge 4.
    tick(2);
    a[1] = 1'b1;
    tick(1);
    a[1] = 1'b0;
    tick(1);
    chk("wu_ch1_pulse", fp0[1], 1);
    chk("wu_ch1_fail", fc0[15:8], 1);
    chk("wu_ch1_pass", pc0[15:8], 0);
    chk("wu_pass_en_low", pe0, 0);
    tick(15);
    chk("pass_en_edge19", pe0, 0);
    chk("ch0_pass_edge19", pc0[7:0], 0);
    tick(1);
    chk("pass_en_edge20", pe0, 1);
    chk("ch0_pass_edge20", pc0[7:0], 0);
    tick(1);
    chk("ch0_pass_edge21", pc0[7:0], 1);
    chk("ch0_fail_edge21", fc0[7:0], 0);

    // Overlapping attempts on ch2 (k=22, k+1=23) both fail at edge 24.
    a[2] = 1'b1;
    tick(1);
    b[2] = 1'b1;
    tick(1);
    a[2] = 1'b0; b[2] = 1'b0;
    tick(1);
    chk("dbl_fail_count", fc0[23:16], 2);
    chk("dbl_fail_pulse", fp0[2], 1);
    chk("dbl_pass_count", pc0[23:16], 0);
    tick(1);
    chk("dbl_pulse_drop", fp0[2], 0);

    // Saturation on ch3 followed by a single-edge clear.
    a[3] = 1'b1; b[3] = 1'b1; c[3] = 1'b1;
    tick(300);
    chk("sat_pass_count", pc0[31:24], 255);
    chk("sat_flag", sat0[3], 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_pass_count", pc0[31:24], 0);
    chk("clr_sat", sat0[3], 0);
    tick(1);
    chk("clr_resume", pc0[31:24], 1);

    // Reset while ch3 attempt (a=1 at last edge) is pending.
    #1 rst = 1'b1;
    a = '0; b = '0; c = '0;
    #1;
    chk_all_zero("midrst");
    #1 rst = 1'b0;
    tick(19);
    chk("rst_pass_en_edge19", pe0, 0);
    chk("rst_abandoned_fail", fc0, 0);
    tick(1);
    chk("rst_pass_en_edge20", pe0, 1);

    // Vacuous counting: a=0 on every channel for 10 post-warm-up edges.
    tick(10);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("vac10_pass[%0d]", i), pc1[i*CW +: CW], 10);
      chk($sformatf("vac10_fail[%0d]", i), fc1[i*CW +: CW], 0);
      chk($sformatf("novac_pass[%0d]", i), pc0[i*CW +: CW], 0);
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
